// File: rtl/slave_in_port.sv
// Serial bus slave front end: decodes the select/ID sequence, deserialises the
// command header and burst beats, and issues one-cycle write/read strobes.
module slave_in_port #(
    parameter int                   SLAVE_LEN = 2,
    parameter logic [SLAVE_LEN-1:0] SLAVE_ID  = 2'd0,
    parameter int                   ADDR_LEN  = 12,
    parameter int                   DATA_LEN  = 8,
    parameter int                   BURST_LEN = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 approval_grant,
    input  logic                 rx_slave_select,
    input  logic                 write_en,
    input  logic                 read_en,
    input  logic                 master_valid,
    input  logic                 rx_address,
    input  logic                 rx_burst_number,
    input  logic                 rx_data,
    output logic                 slave_ready,
    output logic                 selected,
    output logic                 mem_we,
    output logic [ADDR_LEN-1:0]  mem_addr,
    output logic [DATA_LEN-1:0]  mem_wdata,
    output logic                 read_req,
    output logic [ADDR_LEN-1:0]  read_addr,
    output logic [BURST_LEN-1:0] read_burst
);

    localparam int CNT_W = $clog2(ADDR_LEN + BURST_LEN + DATA_LEN + SLAVE_LEN + 17);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        WAIT_CMD = 3'd2,
        RX_HDR   = 3'd3,
        RX_BURST = 3'd4
    } state_t;

    state_t               state_r, state_nx_s;
    logic [CNT_W-1:0]     k_r, k_nx_s;
    logic [SLAVE_LEN-1:0] id_r, id_nx_s;
    logic [ADDR_LEN-1:0]  addr_r, addr_nx_s;
    logic [DATA_LEN-1:0]  data_r, data_nx_s;
    logic [BURST_LEN-1:0] burst_r, burst_nx_s;
    logic [BURST_LEN-1:0] rem_r, rem_nx_s;
    logic [BURST_LEN-1:0] beats_s;
    logic                 flag_r, flag_nx_s;
    logic                 wr_mode_r, wr_mode_nx_s;
    logic                 we_go_s, rd_go_s, sel_set_s, bit_v_s, ready_nx_s;

    // Next-state, field capture and strobe decisions.
    always_comb begin
        state_nx_s   = state_r;
        k_nx_s       = k_r;
        id_nx_s      = id_r;
        addr_nx_s    = addr_r;
        data_nx_s    = data_r;
        burst_nx_s   = burst_r;
        rem_nx_s     = rem_r;
        flag_nx_s    = flag_r;
        wr_mode_nx_s = wr_mode_r;
        beats_s      = {BURST_LEN{1'b0}};
        we_go_s      = 1'b0;
        rd_go_s      = 1'b0;
        sel_set_s    = 1'b0;
        // Bits are only taken while the slave advertises readiness.
        bit_v_s      = master_valid && slave_ready;
        if ((state_r != IDLE) && !approval_grant) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (approval_grant && rx_slave_select) begin
                        state_nx_s = SELECT;
                        k_nx_s     = {CNT_W{1'b0}};
                        id_nx_s    = {SLAVE_LEN{1'b0}};
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                SELECT: begin
                    id_nx_s = id_r | (SLAVE_LEN'(rx_slave_select) << k_r);
                    k_nx_s  = k_r + CNT_W'(1);
                    if (k_r == CNT_W'(SLAVE_LEN - 1)) begin
                        k_nx_s = {CNT_W{1'b0}};
                        if (id_nx_s == SLAVE_ID) begin
                            state_nx_s = WAIT_CMD;
                            sel_set_s  = 1'b1;
                        end else begin
                            state_nx_s = IDLE;
                        end
                    end else begin
                        state_nx_s = SELECT;
                    end
                end
                WAIT_CMD: begin
                    k_nx_s = k_r + CNT_W'(1);
                    if (write_en || read_en) begin
                        state_nx_s   = RX_HDR;
                        wr_mode_nx_s = write_en;
                        k_nx_s       = {CNT_W{1'b0}};
                        addr_nx_s    = {ADDR_LEN{1'b0}};
                        data_nx_s    = {DATA_LEN{1'b0}};
                        burst_nx_s   = {BURST_LEN{1'b0}};
                        flag_nx_s    = 1'b0;
                    end else if (k_r == CNT_W'(15)) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = WAIT_CMD;
                    end
                end
                RX_HDR: begin
                    if (bit_v_s) begin
                        // Shifts past the field width fall off, so no range guards are needed.
                        addr_nx_s  = addr_r | (ADDR_LEN'(rx_address) << k_r);
                        burst_nx_s = burst_r | (BURST_LEN'(rx_burst_number) << (k_r - CNT_W'(1)));
                        flag_nx_s  = (k_r == {CNT_W{1'b0}}) ? rx_burst_number : flag_r;
                        if (wr_mode_r) begin
                            data_nx_s = data_r | (DATA_LEN'(rx_data) << k_r);
                        end else begin
                            data_nx_s = data_r;
                        end
                        if (k_r == {CNT_W{1'b0}}) begin
                            burst_nx_s = burst_r;
                        end else begin
                            flag_nx_s = flag_r;
                        end
                        k_nx_s  = k_r + CNT_W'(1);
                        beats_s = flag_nx_s ? burst_nx_s : BURST_LEN'(1);
                        if (flag_nx_s ? (k_r == CNT_W'(BURST_LEN)) : (k_r == CNT_W'(ADDR_LEN - 1))) begin
                            k_nx_s = {CNT_W{1'b0}};
                            if (wr_mode_r) begin
                                we_go_s = 1'b1;
                                if (beats_s > BURST_LEN'(1)) begin
                                    state_nx_s = RX_BURST;
                                    rem_nx_s   = beats_s - BURST_LEN'(1);
                                end else begin
                                    state_nx_s = IDLE;
                                end
                            end else begin
                                rd_go_s    = 1'b1;
                                state_nx_s = IDLE;
                            end
                        end else begin
                            state_nx_s = RX_HDR;
                        end
                    end else begin
                        state_nx_s = RX_HDR;
                    end
                end
                RX_BURST: begin
                    if (bit_v_s) begin
                        data_nx_s = data_r | (DATA_LEN'(rx_data) << k_r);
                        k_nx_s    = k_r + CNT_W'(1);
                        if (k_r == CNT_W'(DATA_LEN - 1)) begin
                            k_nx_s   = {CNT_W{1'b0}};
                            we_go_s  = 1'b1;
                            rem_nx_s = rem_r - BURST_LEN'(1);
                            if (rem_r == BURST_LEN'(1)) begin
                                state_nx_s = IDLE;
                            end else begin
                                state_nx_s = RX_BURST;
                            end
                        end else begin
                            state_nx_s = RX_BURST;
                        end
                    end else begin
                        state_nx_s = RX_BURST;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
        ready_nx_s = ((state_nx_s == WAIT_CMD) || (state_nx_s == RX_HDR) ||
                      (state_nx_s == RX_BURST)) && !we_go_s && !rd_go_s;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Counters and shift registers; beat data clears after each write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_r       <= {CNT_W{1'b0}};
            id_r      <= {SLAVE_LEN{1'b0}};
            addr_r    <= {ADDR_LEN{1'b0}};
            data_r    <= {DATA_LEN{1'b0}};
            burst_r   <= {BURST_LEN{1'b0}};
            rem_r     <= {BURST_LEN{1'b0}};
            flag_r    <= 1'b0;
            wr_mode_r <= 1'b0;
        end else begin
            k_r       <= k_nx_s;
            id_r      <= id_nx_s;
            addr_r    <= addr_nx_s;
            data_r    <= we_go_s ? {DATA_LEN{1'b0}} : data_nx_s;
            burst_r   <= burst_nx_s;
            rem_r     <= rem_nx_s;
            flag_r    <= flag_nx_s;
            wr_mode_r <= wr_mode_nx_s;
        end
    end

    // Registered outputs; address/data/burst hold between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slave_ready <= 1'b0;
            selected    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= {ADDR_LEN{1'b0}};
            mem_wdata   <= {DATA_LEN{1'b0}};
            read_req    <= 1'b0;
            read_addr   <= {ADDR_LEN{1'b0}};
            read_burst  <= {BURST_LEN{1'b0}};
        end else begin
            slave_ready <= ready_nx_s;
            selected    <= (state_nx_s == IDLE) ? 1'b0 : (selected || sel_set_s);
            mem_we      <= we_go_s;
            read_req    <= rd_go_s;
            if (we_go_s) begin
                mem_addr  <= (state_r == RX_BURST) ? (mem_addr + ADDR_LEN'(1)) : addr_nx_s;
                mem_wdata <= data_nx_s;
            end
            if (rd_go_s) begin
                read_addr  <= addr_nx_s;
                read_burst <= (beats_s == {BURST_LEN{1'b0}}) ? BURST_LEN'(1) : beats_s;
            end
        end
    end

endmodule

// File: tb/tb_slave_in_port.sv
// Directed bench for slave_in_port (SLAVE_ID=2'b10): select, write, burst,
// read, stall, grant abort and mid-burst reset.
module tb_slave_in_port;

    logic        clk = 1'b0;
    logic        reset, approval_grant, rx_slave_select, write_en, read_en;
    logic        master_valid, rx_address, rx_burst_number, rx_data;
    logic        slave_ready, selected, mem_we, read_req;
    logic [11:0] mem_addr, read_addr, read_burst;
    logic [7:0]  mem_wdata;

    int errors = 0;
    int checks = 0;

    logic [11:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [11:0] ra_q[$];
    logic [11:0] rb_q[$];

    slave_in_port #(.SLAVE_ID(2'b10)) dut (
        .clk(clk), .reset(reset), .approval_grant(approval_grant),
        .rx_slave_select(rx_slave_select), .write_en(write_en), .read_en(read_en),
        .master_valid(master_valid), .rx_address(rx_address),
        .rx_burst_number(rx_burst_number), .rx_data(rx_data),
        .slave_ready(slave_ready), .selected(selected), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .read_req(read_req),
        .read_addr(read_addr), .read_burst(read_burst)
    );

    always #5 clk = ~clk;

    // Strobe monitor: one entry per high cycle of each strobe.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (read_req === 1'b1) begin
            ra_q.push_back(read_addr);
            rb_q.push_back(read_burst);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_select(input logic b1, input logic b2);
        rx_slave_select = 1'b1; @(negedge clk);
        rx_slave_select = b1;   @(negedge clk);
        rx_slave_select = b2;   @(negedge clk);
        rx_slave_select = 1'b0;
    endtask

    task automatic hdr(input logic wr, input logic rd, input logic [11:0] a, input logic fl,
                       input logic [11:0] b, input logic [7:0] d, input int stall_k, input int drop_k);
        logic [12:0] ax, bx, dx;
        int last;
        ax = {1'b0, a};
        bx = {b, fl};
        dx = {5'd0, d};
        last = fl ? 12 : 11;
        write_en = wr; read_en = rd; @(negedge clk);
        write_en = 1'b0; read_en = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (k == stall_k) begin
                master_valid = 1'b0; rx_address = 1'b1; rx_burst_number = 1'b1; rx_data = 1'b1;
                repeat (3) @(negedge clk);
            end
            if (k == drop_k) begin
                approval_grant = 1'b0; master_valid = 1'b0; @(negedge clk);
                approval_grant = 1'b1;
                return;
            end
            master_valid = 1'b1; rx_address = ax[k]; rx_burst_number = bx[k]; rx_data = dx[k];
            @(negedge clk);
        end
        master_valid = 1'b0; rx_address = 1'b0; rx_burst_number = 1'b0; rx_data = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input int rst_k);
        master_valid = 1'b0; @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k == rst_k) begin
                master_valid = 1'b0;
                #2 reset = 1'b1;
                #1 chk("async_rst_we", mem_we, 0);
                chk("async_rst_ready", slave_ready, 0);
                chk("async_rst_addr", mem_addr, 0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            master_valid = 1'b1; rx_data = d[k];
            @(negedge clk);
        end
        master_valid = 1'b0; rx_data = 1'b0;
    endtask

    initial begin
        reset = 1'b1; approval_grant = 1'b1; rx_slave_select = 1'b0; write_en = 1'b0;
        read_en = 1'b0; master_valid = 1'b0; rx_address = 1'b0; rx_burst_number = 1'b0;
        rx_data = 1'b0;
        #1;
        chk("rst_ready", slave_ready, 0);
        chk("rst_selected", selected, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_read_req", read_req, 0);
        chk("rst_outs", {mem_addr, mem_wdata, read_addr}, 0);
        chk("rst_read_burst", read_burst, 0);
        idle(2);
        reset = 1'b0;
        idle(1);

        // Matching ID, then command timeout after 16 idle cycles.
        do_select(1'b0, 1'b1);
        chk("sel_selected", selected, 1);
        chk("sel_ready", slave_ready, 1);
        idle(15);
        chk("wait_ready_15", slave_ready, 1);
        idle(1);
        chk("timeout_ready", slave_ready, 0);
        chk("timeout_selected", selected, 0);

        // Non-matching ID.
        do_select(1'b1, 1'b1);
        chk("nosel_selected", selected, 0);
        chk("nosel_ready", slave_ready, 0);
        idle(3);
        chk("nosel_strobes", wa_q.size() + ra_q.size(), 0);

        // Single write; write wins when both command lines are high.
        do_select(1'b0, 1'b1);
        hdr(1'b1, 1'b1, 12'h0A5, 1'b0, 12'h000, 8'h3C, -1, -1);
        chk("single_we_now", mem_we, 1);
        chk("single_ready_strobe", slave_ready, 0);
        idle(1);
        chk("single_we_pulse", mem_we, 0);
        idle(1);
        chk("single_cnt", wa_q.size(), 1);
        chk("single_addr", wa_q[0], 12'h0A5);
        chk("single_data", wd_q[0], 8'h3C);
        chk("single_no_read", ra_q.size(), 0);
        chk("single_idle_sel", selected, 0);

        // Burst of 3 wrapping the address space.
        do_select(1'b0, 1'b1);
        hdr(1'b1, 1'b0, 12'hFFE, 1'b1, 12'd3, 8'h11, -1, -1);
        beat(8'h22, -1);
        beat(8'h33, -1);
        idle(2);
        chk("burst_cnt", wa_q.size(), 4);
        chk("burst_a0", wa_q[1], 12'hFFE);
        chk("burst_d0", wd_q[1], 8'h11);
        chk("burst_a1", wa_q[2], 12'hFFF);
        chk("burst_d1", wd_q[2], 8'h22);
        chk("burst_a2", wa_q[3], 12'h000);
        chk("burst_d2", wd_q[3], 8'h33);
        chk("burst_idle_ready", slave_ready, 0);

        // Reads: burst 4, then burst 0 reported as 1.
        do_select(1'b0, 1'b1);
        hdr(1'b0, 1'b1, 12'h100, 1'b1, 12'd4, 8'h00, -1, -1);
        idle(2);
        chk("read_cnt", ra_q.size(), 1);
        chk("read_addr", ra_q[0], 12'h100);
        chk("read_burst", rb_q[0], 12'd4);
        do_select(1'b0, 1'b1);
        hdr(1'b0, 1'b1, 12'h2AB, 1'b1, 12'd0, 8'h00, -1, -1);
        idle(2);
        chk("read0_cnt", ra_q.size(), 2);
        chk("read0_addr", ra_q[1], 12'h2AB);
        chk("read0_burst", rb_q[1], 12'd1);
        chk("read_no_we", wa_q.size(), 4);
        chk("hold_mem_addr", mem_addr, 12'h000);
        chk("hold_mem_wdata", mem_wdata, 8'h33);

        // Three-cycle master_valid stall mid-header.
        do_select(1'b0, 1'b1);
        hdr(1'b1, 1'b0, 12'h5A3, 1'b0, 12'h000, 8'hC6, 5, -1);
        idle(2);
        chk("stall_cnt", wa_q.size(), 5);
        chk("stall_addr", wa_q[4], 12'h5A3);
        chk("stall_data", wd_q[4], 8'hC6);

        // Grant dropped after 5 header bits, then a clean write.
        do_select(1'b0, 1'b1);
        hdr(1'b1, 1'b0, 12'h3C3, 1'b0, 12'h000, 8'h99, -1, 5);
        idle(2);
        chk("drop_no_we", wa_q.size(), 5);
        chk("drop_selected", selected, 0);
        chk("drop_ready", slave_ready, 0);
        do_select(1'b0, 1'b1);
        hdr(1'b1, 1'b0, 12'h123, 1'b0, 12'h000, 8'h45, -1, -1);
        idle(2);
        chk("after_drop_cnt", wa_q.size(), 6);
        chk("after_drop_addr", wa_q[5], 12'h123);
        chk("after_drop_data", wd_q[5], 8'h45);

        // Reset asserted mid-burst, then a clean write.
        do_select(1'b0, 1'b1);
        hdr(1'b1, 1'b0, 12'h200, 1'b1, 12'd2, 8'h77, -1, -1);
        beat(8'h88, 4);
        idle(3);
        chk("rst_burst_cnt", wa_q.size(), 7);
        chk("rst_burst_first", wa_q[6], 12'h200);
        chk("rst_burst_sel", selected, 0);
        do_select(1'b0, 1'b1);
        hdr(1'b1, 1'b0, 12'h0F0, 1'b0, 12'h000, 8'h5A, -1, -1);
        idle(2);
        chk("after_rst_cnt", wa_q.size(), 8);
        chk("after_rst_addr", wa_q[7], 12'h0F0);
        chk("after_rst_data", wd_q[7], 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
